// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolution unit.
package bru_pkg;

  // Byte distance to the sequential successor of an instruction.
  localparam int unsigned INSTR_BYTES = 4;

  // Width of the target field held in each queued prediction.
  localparam int unsigned PC_W = 32;

  typedef enum logic {
    RUN,
    FLUSH
  } state_e;

  typedef struct packed {
    logic            pred;
    logic [PC_W-1:0] target;
  } pred_entry_t;

endpackage

// File: rtl/pred_fifo.sv
// In-order FIFO of fetch-side predictions. Pointers carry one extra wrap bit so
// that full and empty are distinguished without a separate counter. The
// synchronous clear has priority over push and pop.
module pred_fifo
  import bru_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        nrst_in,
  input  logic        push_in,
  input  pred_entry_t wdata_in,
  input  logic        pop_in,
  input  logic        clear_in,
  output pred_entry_t rdata_out,
  output logic        full_out,
  output logic        empty_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wptr_q, rptr_q;
  pred_entry_t mem_q [DEPTH];

  // Pointer update; clear resets both pointers, emptying the queue.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clear_in) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_in) wptr_q <= wptr_q + PTR_ONE;
      if (pop_in)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_in) begin
    if (push_in && !clear_in) mem_q[wptr_q[AW-1:0]] <= wdata_in;
  end

  assign rdata_out = mem_q[rptr_q[AW-1:0]];
  assign empty_out = (wptr_q == rptr_q);
  assign full_out  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/branch_resolver.sv
// Branch resolution unit at EX/MEM. Queues the prediction made for every
// fetched instruction, checks it against the actual outcome when the
// instruction resolves, redirects and flushes fetch on a mispredict, and feeds
// the registered outcome of every branch/jump back to the predictor.
// Optional build macro BRU_STATS_EN adds saturating branch/mispredict counters.
// PC is expected to equal bru_pkg::PC_W (width of the queued target field).
module branch_resolver
  import bru_pkg::*;
#(
  parameter int unsigned PC           = PC_W,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic          clk_in,
  input  logic          nrst_in,
  input  logic          fetch_valid_in,
  input  logic          fetch_prediction_in,
  input  logic [PC-1:0] fetch_pc_prediction_in,
  output logic          fetch_ready_out,
  input  logic          exmem_valid_in,
  input  logic          exmem_jmp_br_in,
  input  logic          exmem_taken_in,
  input  logic [PC-1:0] exmem_pc_in,
  input  logic [PC-1:0] exmem_target_in,
  output logic          bpu_update_out,
  output logic          bpu_pc_src_out,
  output logic [PC-1:0] bpu_pc_out,
  output logic [PC-1:0] bpu_target_out,
  output logic          redirect_out,
  output logic [PC-1:0] redirect_pc_out,
  output logic          flush_out,
`ifdef BRU_STATS_EN
  output logic [31:0]   branch_count_out,
  output logic [31:0]   mispredict_count_out,
`endif
  output logic          qerr_out
);

  localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           flush_q, flush_d;

  logic           fifo_full, fifo_empty;
  pred_entry_t    head, wentry;
  logic           run, push, resolve, pop, pop_empty, update;
  logic           target_hit, mispredict;
  logic [PC-1:0]  correct_pc;

  logic           bpu_update_q, bpu_pc_src_q, redirect_q, qerr_q;
  logic [PC-1:0]  bpu_pc_q, bpu_target_q, redirect_pc_q;

  assign run             = (state_q == RUN);
  assign fetch_ready_out = run && !fifo_full;
  assign push            = fetch_valid_in && fetch_ready_out;
  assign resolve         = run && exmem_valid_in;
  assign pop             = resolve && !fifo_empty;
  assign pop_empty       = resolve && fifo_empty;
  assign update          = pop && exmem_jmp_br_in;

  assign wentry = '{pred: fetch_prediction_in, target: PC_W'(fetch_pc_prediction_in)};

  pred_fifo #(
    .DEPTH(DEPTH)
  ) u_pred_fifo (
    .clk_in   (clk_in),
    .nrst_in  (nrst_in),
    .push_in  (push),
    .wdata_in (wentry),
    .pop_in   (pop),
    .clear_in (mispredict),
    .rdata_out(head),
    .full_out (fifo_full),
    .empty_out(fifo_empty)
  );

  assign target_hit = (exmem_target_in == PC'(head.target));
  // Non-branches fall through, so only a taken branch/jump uses its target.
  assign correct_pc = (exmem_jmp_br_in && exmem_taken_in) ? exmem_target_in
                                                           : exmem_pc_in + PC'(INSTR_BYTES);

  // Compare the popped prediction with the actual outcome.
  always_comb begin
    mispredict = 1'b0;
    if (pop) begin
      if (exmem_jmp_br_in) begin
        mispredict = (exmem_taken_in != head.pred) || (exmem_taken_in && !target_hit);
      end else begin
        mispredict = head.pred;
      end
    end
  end

  // Next-state logic: a mispredict opens a flush window of FLUSH_CYCLES cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    case (state_q)
      RUN: begin
        if (mispredict) begin
          state_d = FLUSH;
          cnt_d   = CW'(FLUSH_CYCLES);
          flush_d = 1'b1;
        end
      end
      FLUSH: begin
        if (cnt_q == CW'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
          flush_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
        flush_d = 1'b0;
      end
    endcase
  end

  // FSM state, flush counter and registered flush output.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q <= RUN;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  // Registered predictor update, redirect and sticky queue error.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      bpu_update_q  <= 1'b0;
      bpu_pc_src_q  <= 1'b0;
      bpu_pc_q      <= '0;
      bpu_target_q  <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      qerr_q        <= 1'b0;
    end else begin
      bpu_update_q <= update;
      if (update) begin
        bpu_pc_src_q <= exmem_taken_in;
        bpu_pc_q     <= exmem_pc_in;
        bpu_target_q <= exmem_target_in;
      end
      redirect_q <= mispredict;
      if (mispredict) redirect_pc_q <= correct_pc;
      if (pop_empty) qerr_q <= 1'b1;
    end
  end

  assign bpu_update_out  = bpu_update_q;
  assign bpu_pc_src_out  = bpu_pc_src_q;
  assign bpu_pc_out      = bpu_pc_q;
  assign bpu_target_out  = bpu_target_q;
  assign redirect_out    = redirect_q;
  assign redirect_pc_out = redirect_pc_q;
  assign flush_out       = flush_q;
  assign qerr_out        = qerr_q;

`ifdef BRU_STATS_EN
  logic [31:0] branch_cnt_q, mispredict_cnt_q;

  // Saturating statistics, updated alongside the update/redirect registers.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (update && (branch_cnt_q != '1)) branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict && (mispredict_cnt_q != '1)) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
    end
  end

  assign branch_count_out     = branch_cnt_q;
  assign mispredict_count_out = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed vector table, hand-written
// flush/full/qerr/reset sequences, and randomized traffic against a queue model.
module tb_branch_resolver;

  localparam int unsigned PC           = 32;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned FLUSH_CYCLES = 2;

  logic          clk = 1'b0;
  logic          nrst;
  logic          fetch_valid, fetch_pred;
  logic [PC-1:0] fetch_tgt;
  logic          fetch_ready;
  logic          ex_valid, ex_br, ex_taken;
  logic [PC-1:0] ex_pc, ex_tgt;
  logic          upd, upd_src, redir, flush, qerr;
  logic [PC-1:0] upd_pc, upd_tgt, redir_pc;

  always #5 clk = ~clk;

  branch_resolver #(
    .PC          (PC),
    .DEPTH       (DEPTH),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk_in                (clk),
    .nrst_in               (nrst),
    .fetch_valid_in        (fetch_valid),
    .fetch_prediction_in   (fetch_pred),
    .fetch_pc_prediction_in(fetch_tgt),
    .fetch_ready_out       (fetch_ready),
    .exmem_valid_in        (ex_valid),
    .exmem_jmp_br_in       (ex_br),
    .exmem_taken_in        (ex_taken),
    .exmem_pc_in           (ex_pc),
    .exmem_target_in       (ex_tgt),
    .bpu_update_out        (upd),
    .bpu_pc_src_out        (upd_src),
    .bpu_pc_out            (upd_pc),
    .bpu_target_out        (upd_tgt),
    .redirect_out          (redir),
    .redirect_pc_out       (redir_pc),
    .flush_out             (flush),
    .qerr_out              (qerr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_valid = 1'b0; fetch_pred = 1'b0; fetch_tgt = '0;
    ex_valid = 1'b0; ex_br = 1'b0; ex_taken = 1'b0; ex_pc = '0; ex_tgt = '0;
  endtask

  task automatic push(input logic pred, input logic [31:0] tgt);
    fetch_valid = 1'b1; fetch_pred = pred; fetch_tgt = tgt;
    step();
    fetch_valid = 1'b0;
  endtask

  task automatic resolve(input logic br, input logic tk, input logic [31:0] pc,
                         input logic [31:0] tgt);
    ex_valid = 1'b1; ex_br = br; ex_taken = tk; ex_pc = pc; ex_tgt = tgt;
    step();
    ex_valid = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #3;
    @(negedge clk);
    nrst = 1'b1;
    step();
  endtask

  // Directed single-resolution vectors.
  typedef struct {
    logic        pred;
    logic [31:0] ptgt;
    logic        br, taken;
    logic [31:0] pc, tgt;
    logic        exp_upd, exp_redir;
    logic [31:0] exp_rpc;
  } vec_t;

  vec_t vecs[7];

  // Reference model: a plain queue of predictions plus a flush countdown.
  typedef struct {
    logic        pred;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  int          m_flush;
  logic        m_qerr, m_upd, m_redir, m_src;
  logic [31:0] m_pc, m_tgt, m_rpc;

  task automatic model_step();
    ent_t e;
    logic ready, do_push, mis;
    ready = (mq.size() < DEPTH) && (m_flush == 0);
    chk("rand_ready", fetch_ready, ready);
    m_upd = 1'b0;
    m_redir = 1'b0;
    if (m_flush > 0) begin
      m_flush--;
    end else begin
      do_push = fetch_valid && ready;
      mis = 1'b0;
      if (ex_valid) begin
        if (mq.size() == 0) begin
          m_qerr = 1'b1;
        end else begin
          e = mq.pop_front();
          if (ex_br) begin
            m_upd = 1'b1; m_src = ex_taken; m_pc = ex_pc; m_tgt = ex_tgt;
            mis = (ex_taken != e.pred) || (ex_taken && (ex_tgt != e.tgt));
          end else begin
            mis = e.pred;
          end
          if (mis) m_rpc = (ex_br && ex_taken) ? ex_tgt : ex_pc + 32'd4;
        end
      end
      if (do_push) mq.push_back('{pred: fetch_pred, tgt: fetch_tgt});
      if (mis) begin
        mq.delete();
        m_flush = FLUSH_CYCLES;
        m_redir = 1'b1;
      end
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h100, 1'b1, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h200, 1'b1, 1'b1, 32'h200};
    vecs[2] = '{1'b1, 32'h100, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h100, 1'b1, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 32'h100, 1'b1, 1'b1, 32'h10, 32'h104, 1'b1, 1'b1, 32'h104};
    vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h300, 1'b1, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 32'h300, 1'b0, 1'b0, 32'h50, 32'h0, 1'b0, 1'b1, 32'h54};
    vecs[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h60, 32'h0, 1'b0, 1'b0, 32'h0};

    idle();
    nrst = 1'b0;
    #12;
    chk("rst_ready", fetch_ready, 1'b1);
    chk("rst_upd", upd, 1'b0);
    chk("rst_redir", redir, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_qerr", qerr, 1'b0);
    chk("rst_upd_pc", upd_pc, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    step();

    // Vector table: push one prediction, resolve it, check the next cycle.
    for (int i = 0; i < 7; i++) begin
      push(vecs[i].pred, vecs[i].ptgt);
      resolve(vecs[i].br, vecs[i].taken, vecs[i].pc, vecs[i].tgt);
      chk($sformatf("vec%0d_upd", i), upd, vecs[i].exp_upd);
      chk($sformatf("vec%0d_redir", i), redir, vecs[i].exp_redir);
      chk($sformatf("vec%0d_flush", i), flush, vecs[i].exp_redir);
      if (vecs[i].exp_redir) chk($sformatf("vec%0d_rpc", i), redir_pc, vecs[i].exp_rpc);
      if (vecs[i].exp_upd) begin
        chk($sformatf("vec%0d_pc", i), upd_pc, vecs[i].pc);
        chk($sformatf("vec%0d_src", i), upd_src, vecs[i].taken);
        chk($sformatf("vec%0d_tgt", i), upd_tgt, vecs[i].tgt);
      end
      repeat (3) step();
      chk($sformatf("vec%0d_qerr", i), qerr, 1'b0);
    end

    // Mispredict with a second entry queued behind it; resolve held high
    // through the flush window, where it must be ignored.
    push(1'b0, 32'h0);
    push(1'b1, 32'h300);
    ex_valid = 1'b1; ex_br = 1'b1; ex_taken = 1'b1; ex_pc = 32'h80; ex_tgt = 32'h200;
    step();
    chk("fl1_redir", redir, 1'b1);
    chk("fl1_rpc", redir_pc, 32'h200);
    chk("fl1_flush", flush, 1'b1);
    chk("fl1_ready", fetch_ready, 1'b0);
    step();
    chk("fl2_redir", redir, 1'b0);
    chk("fl2_flush", flush, 1'b1);
    chk("fl2_ready", fetch_ready, 1'b0);
    chk("fl2_upd", upd, 1'b0);
    step();
    chk("fl3_flush", flush, 1'b0);
    chk("fl3_ready", fetch_ready, 1'b1);
    chk("fl3_upd", upd, 1'b0);
    chk("fl3_qerr", qerr, 1'b0);
    idle();

    // Fill the (cleared) queue: ready must drop after exactly DEPTH pushes.
    fetch_valid = 1'b1; fetch_pred = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("fill%0d_ready", i), fetch_ready, 1'b1);
      step();
    end
    chk("full_ready", fetch_ready, 1'b0);
    // Pop while full with fetch still valid: the push is not accepted.
    ex_valid = 1'b1; ex_br = 1'b0; ex_taken = 1'b0; ex_pc = 32'h400;
    step();
    fetch_valid = 1'b0;
    chk("popfull_ready", fetch_ready, 1'b1);
    chk("popfull_redir", redir, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) begin
      step();
      chk($sformatf("drain%0d_qerr", i), qerr, 1'b0);
    end
    // Queue is now empty: the next pop is an error, with no update.
    ex_br = 1'b1;
    step();
    chk("qerr_set", qerr, 1'b1);
    chk("qerr_upd", upd, 1'b0);
    idle();
    repeat (2) step();
    chk("qerr_sticky", qerr, 1'b1);

    // Reset asserted in the first flush cycle.
    push(1'b0, 32'h0);
    resolve(1'b1, 1'b1, 32'h80, 32'h200);
    chk("rf_redir", redir, 1'b1);
    nrst = 1'b0;
    #1;
    chk("rf_flush", flush, 1'b0);
    chk("rf_ready", fetch_ready, 1'b1);
    chk("rf_redir0", redir, 1'b0);
    chk("rf_rpc0", redir_pc, 32'h0);
    chk("rf_upd0", upd, 1'b0);
    chk("rf_upd_pc0", upd_pc, 32'h0);
    chk("rf_qerr0", qerr, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    step();
    chk("rf_after_flush", flush, 1'b0);

    // Randomized traffic against the queue model.
    idle();
    do_reset();
    mq.delete();
    m_flush = 0;
    m_qerr = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      fetch_valid = 1'($urandom);
      fetch_pred  = 1'($urandom);
      fetch_tgt   = ($urandom % 2 != 0) ? 32'h100 : 32'h200;
      ex_valid    = ($urandom % 3) != 0;
      ex_br       = 1'($urandom);
      ex_taken    = 1'($urandom);
      ex_tgt      = ($urandom % 2 != 0) ? 32'h100 : 32'h200;
      ex_pc       = ($urandom % 8 == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      if ((mq.size() > 0) && ($urandom % 4 != 0)) begin
        ex_taken = mq[0].pred;
        ex_tgt   = mq[0].tgt;
        if (ex_taken) ex_br = 1'b1;
      end
      model_step();
      step();
      chk("rand_upd", upd, m_upd);
      chk("rand_redir", redir, m_redir);
      chk("rand_flush", flush, m_flush > 0);
      chk("rand_qerr", qerr, m_qerr);
      if (m_upd) begin
        chk("rand_upd_pc", upd_pc, m_pc);
        chk("rand_upd_src", upd_src, m_src);
        chk("rand_upd_tgt", upd_tgt, m_tgt);
      end
      if (m_redir) chk("rand_rpc", redir_pc, m_rpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
